clk_en_nco_multi: RTL

- Parametrised, multi-channel successor to the fixed two-output system PLL wrapper.
- Runs on one PLL output clock, e.g. 57.272728 MHz, and derives CHANNELS fractional clock-enable streams. Each stream has a programmable frequency (NCO increment) and a programmable phase offset.
- Lets cores retune NTSC/PAL CPU/video enables at runtime without PLL reconfiguration.
- Includes a lock indicator for downstream reset release.

---
 rtl/clk_en_nco_multi.sv | 137 +++++++++++++
 1 files changed

// File: rtl/clk_en_nco_multi.sv
// ============================================================================
//  Module   : clk_en_nco_multi
//  Purpose  : Multi-channel fractional clock-enable NCO with per-channel
//             increment/phase registers, sync realign and lock indicator.
//             Optional clk_o duty-cycle outputs when CLK_EN_NCO_DUTY_EN is set.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_en_nco_multi #(
   parameter int          CHANNELS    = 2,
   parameter int          ACC_W       = 32,
   parameter logic [31:0] DEFAULT_INC = 32'h0800_0000
) (
   input  logic                refclk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] run,
   input  logic                sync,
   input  logic                cfg_wr,
   input  logic                cfg_rd,
   input  logic [2:0]          cfg_ch,
   input  logic                cfg_sel,
   input  logic [ACC_W-1:0]    cfg_wdata,
   output logic [ACC_W-1:0]    cfg_rdata,
   output logic                cfg_rvalid,
   output logic [CHANNELS-1:0] ce_o,
`ifdef CLK_EN_NCO_DUTY_EN
   output logic [CHANNELS-1:0] clk_o,
`endif
   output logic                locked
);

   localparam logic [ACC_W-1:0] c_def_inc = DEFAULT_INC[ACC_W-1:0];

   logic [ACC_W-1:0]    r_acc   [CHANNELS];
   logic [ACC_W-1:0]    r_inc   [CHANNELS];
   logic [ACC_W-1:0]    r_phase [CHANNELS];
   logic [CHANNELS-1:0] r_ce;
   logic [CHANNELS-1:0] r_seen;
   logic                r_locked;
   logic [ACC_W-1:0]    r_rdata;
   logic                r_rvalid;

   logic [ACC_W-1:0]    w_sum   [CHANNELS];
   logic [CHANNELS-1:0] w_carry;
   logic [CHANNELS-1:0] w_wr_inc;
   logic [CHANNELS-1:0] w_wr_ph;
   logic [CHANNELS-1:0] w_sat;
   logic [ACC_W-1:0]    w_rd_val;

   always_comb begin
      w_carry  = '0;
      w_wr_inc = '0;
      w_wr_ph  = '0;
      w_sat    = '0;
      w_rd_val = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_sum[i] = '0;
         {w_carry[i], w_sum[i]} = {1'b0, r_acc[i]} + {1'b0, r_inc[i]};
         w_wr_inc[i] = cfg_wr && !cfg_sel && (cfg_ch == 3'(i));
         w_wr_ph[i]  = cfg_wr &&  cfg_sel && (cfg_ch == 3'(i));
         w_sat[i]    = r_seen[i] || !run[i] || (r_inc[i] == '0);
         // Out-of-range channel indices match nothing and read back as zero
         if (cfg_ch == 3'(i))
            w_rd_val = cfg_sel ? r_phase[i] : r_inc[i];
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_acc[i]   <= '0;
            r_phase[i] <= '0;
            r_inc[i]   <= c_def_inc;
         end
         r_ce     <= '0;
         r_seen   <= '0;
         r_locked <= 1'b0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (w_wr_inc[i])
               r_inc[i] <= cfg_wdata;
            if (w_wr_ph[i])
               r_phase[i] <= cfg_wdata;
            // Non-blocking read of r_phase gives the pre-write value on a coincident write
            if (sync)
               r_acc[i] <= r_phase[i];
            else if (run[i])
               r_acc[i] <= w_sum[i];
         end
         if (sync) begin
            r_ce     <= '0;
            r_seen   <= '0;
            r_locked <= 1'b0;
         end else begin
            r_ce     <= run & w_carry;
            r_seen   <= r_seen | (run & w_carry);
            r_locked <= r_locked | (&w_sat);
         end
         r_rvalid <= cfg_rd;
         if (cfg_rd)
            r_rdata <= w_rd_val;
      end
   end

`ifdef CLK_EN_NCO_DUTY_EN
   logic [CHANNELS-1:0] r_clk;

   // Tracks the MSB of the accumulator value that is being loaded this edge
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (sync)
               r_clk[i] <= r_phase[i][ACC_W-1];
            else if (run[i])
               r_clk[i] <= w_sum[i][ACC_W-1];
            else
               r_clk[i] <= r_acc[i][ACC_W-1];
         end
      end
   end

   assign clk_o = r_clk;
`endif

   assign ce_o       = r_ce;
   assign locked     = r_locked;
   assign cfg_rdata  = r_rdata;
   assign cfg_rvalid = r_rvalid;

endmodule

`default_nettype wire
